// File: rtl/sram_pkg.sv
// Shared types and defaults for the 32-bit-word to 16-bit-SRAM responder.
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int unsigned DEF_PHASE_CYCLES = 3;
  localparam int unsigned DEF_BASE_ADDR    = 1024;
  localparam int unsigned DEF_SRAM_AW      = 18;

  // Appended as the SRAM address LSB to pick the half of a word.
  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

endpackage

// File: rtl/sram_word_responder_if.sv
// Word request/response bus between the cache controller and the SRAM responder.
interface sram_word_responder_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic        ready;

  modport master (output wr_en, rd_en, address, writeData, input readData, ready);
  modport slave  (input wr_en, rd_en, address, writeData, output readData, ready);
endinterface

// File: rtl/sram_word_responder.sv
// Executes each 32-bit word request as two timed 16-bit SRAM accesses (low half, then high half).
module sram_word_responder
  import sram_pkg::*;
#(
  parameter int unsigned PHASE_CYCLES = DEF_PHASE_CYCLES,
  parameter int unsigned BASE_ADDR    = DEF_BASE_ADDR,
  parameter int unsigned SRAM_AW      = DEF_SRAM_AW
) (
  input  logic                clk,
  input  logic                rst,
  sram_word_responder_if.slave bus,
  inout  wire  [15:0]         SRAM_DQ,
  output logic [SRAM_AW-1:0]  SRAM_ADDR,
  output logic                SRAM_UB_N,
  output logic                SRAM_LB_N,
  output logic                SRAM_CE_N,
  output logic                SRAM_WE_N,
  output logic                SRAM_OE_N
);

  localparam int unsigned CW = $clog2(PHASE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(PHASE_CYCLES - 1);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 op_wr_q, op_wr_d;
  logic [SRAM_AW-2:0]   word_q, word_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [31:0]          rdata_q;
  logic [SRAM_AW-1:0]   addr_q;
  logic                 we_n_q, oe_n_q, dq_oe_q;
  logic [15:0]          dq_out_q;

  logic                 req, last, act_d, half_d;
  logic [SRAM_AW-2:0]   word_in;

  assign req     = bus.wr_en | bus.rd_en;
  assign last    = (cnt_q == LAST);
  assign word_in = (SRAM_AW-1)'((bus.address - 32'(BASE_ADDR)) >> 2);

  // Next state plus the request fields as they will look once the sampling edge has passed.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: if (req) begin
        state_d = LO;
        cnt_d   = '0;
        op_wr_d = bus.wr_en;
        word_d  = word_in;
        wdata_d = bus.writeData;
      end
      LO: if (last) begin
        state_d = HI;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      HI: if (last) begin
        state_d = DONE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign act_d  = (state_d == LO) || (state_d == HI);
  assign half_d = (state_d == HI) ? HALF_HI : HALF_LO;

  // Strobes are registered from next-state values so they line up with the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_wr_q  <= 1'b0;
      word_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      addr_q   <= '0;
      we_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      dq_oe_q  <= 1'b0;
      dq_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_wr_q  <= op_wr_d;
      word_q   <= word_d;
      wdata_q  <= wdata_d;
      // Last write cycle of each phase keeps data on the bus with WE_N high for hold time.
      we_n_q   <= !(act_d && op_wr_d && (cnt_d != LAST));
      oe_n_q   <= !(act_d && !op_wr_d);
      dq_oe_q  <= act_d && op_wr_d;
      dq_out_q <= (half_d == HALF_HI) ? wdata_d[31:16] : wdata_d[15:0];
      if (act_d)
        addr_q <= {word_d, half_d};
      if (!op_wr_q && last && (state_q == LO))
        rdata_q[15:0] <= SRAM_DQ;
      if (!op_wr_q && last && (state_q == HI))
        rdata_q[31:16] <= SRAM_DQ;
    end
  end

  assign SRAM_DQ   = dq_oe_q ? dq_out_q : 16'hzzzz;
  assign SRAM_ADDR = addr_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;

  assign bus.readData = rdata_q;
  assign bus.ready    = (state_q == DONE) || ((state_q == IDLE) && !req);

endmodule

// File: tb/tb_sram_word_responder.sv
// Random word traffic against a word-level memory model, with a simple SRAM chip on the pins.
module tb_sram_word_responder;

  localparam int PC = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_word_responder_if bus();
  wire  [15:0] SRAM_DQ;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_WE_N, SRAM_OE_N;

  sram_word_responder dut (
    .clk(clk), .rst(rst), .bus(bus),
    .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR),
    .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N), .SRAM_CE_N(SRAM_CE_N),
    .SRAM_WE_N(SRAM_WE_N), .SRAM_OE_N(SRAM_OE_N)
  );

  // Board SRAM: writes while WE_N is low, drives the bus when output-enabled.
  logic [15:0] chip [0:1023];
  assign SRAM_DQ = (!SRAM_OE_N && SRAM_WE_N) ? chip[SRAM_ADDR[9:0]] : 16'hzzzz;
  always @(posedge clk) if (!SRAM_WE_N) chip[SRAM_ADDR[9:0]] <= SRAM_DQ;

  int nvec = 0;
  int nbad = 0;
  logic [31:0] model [0:15];
  logic [31:0] last_rd = 32'h0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic access(input bit wr, input bit rd, input int w, input logic [31:0] wd,
                        input bit drop);
    int n, we_lo, oe_lo;
    bit seen;
    logic [17:0] wa;
    wa = 18'(w * 2);
    @(negedge clk);
    bus.address   = 32'(1024 + w * 4 + int'($urandom_range(0, 3)));
    bus.writeData = wd;
    bus.wr_en     = wr;
    bus.rd_en     = rd;
    #1 chk("rdy_pend", 32'(bus.ready), 32'd0);
    @(posedge clk);
    n = 0; seen = 0; we_lo = 0; oe_lo = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      if (n == 0) chk("addr_lo", 32'(SRAM_ADDR), 32'(wa));
      if (n == PC) chk("addr_hi", 32'(SRAM_ADDR), 32'(wa | 18'd1));
      if (bus.ready) seen = 1;
      else begin
        we_lo += int'(!SRAM_WE_N);
        oe_lo += int'(!SRAM_OE_N);
      end
      if (n == 0) begin
        bus.address   = $urandom;
        bus.writeData = $urandom;
      end
      if (drop && n == 1) begin
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
      end
      if (!seen) begin
        @(posedge clk);
        n++;
      end
    end
    chk("latency", 32'(n), 32'(2 * PC));
    if (wr) begin
      chk("we_cnt", 32'(we_lo), 32'(2 * (PC - 1)));
      chk("oe_cnt", 32'(oe_lo), 32'd0);
      model[w] = wd;
      chk("chip_lo", 32'(chip[wa[9:0]]), 32'(wd[15:0]));
      chk("chip_hi", 32'(chip[wa[9:0] + 10'd1]), 32'(wd[31:16]));
      chk("rd_hold", bus.readData, last_rd);
    end else begin
      chk("we_cnt", 32'(we_lo), 32'd0);
      chk("oe_cnt", 32'(oe_lo), 32'(2 * PC));
      chk("rdata", bus.readData, model[w]);
      last_rd = model[w];
    end
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    @(negedge clk);
    chk("idle_rdy", 32'(bus.ready), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) chip[i] = 16'h0;
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    bus.address = 32'h0; bus.writeData = 32'h0;
    #12;
    chk("rst_rdata", bus.readData, 32'h0);
    chk("rst_addr", 32'(SRAM_ADDR), 32'h0);
    chk("rst_we", 32'(SRAM_WE_N), 32'd1);
    chk("rst_oe", 32'(SRAM_OE_N), 32'd1);
    chk("rst_rdy", 32'(bus.ready), 32'd1);
    @(negedge clk); rst = 1'b0;

    access(1, 0, 0, 32'hDEADBEEF, 0);
    access(0, 1, 0, 32'h0, 0);
    access(1, 0, 1, 32'h12345678, 0);
    access(0, 1, 0, 32'h0, 0);
    access(0, 1, 1, 32'h0, 0);
    access(1, 1, 2, 32'hA5A5A5A5, 0);
    access(0, 1, 2, 32'h0, 0);
    access(0, 1, 1, 32'h0, 1);

    // Reset in the middle of the high-half write.
    @(negedge clk);
    bus.address = 32'd1048; bus.writeData = 32'h13579BDF; bus.wr_en = 1'b1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.wr_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_we", 32'(SRAM_WE_N), 32'd1);
    chk("mid_oe", 32'(SRAM_OE_N), 32'd1);
    chk("mid_rdata", bus.readData, 32'h0);
    chk("mid_rdy", 32'(bus.ready), 32'd1);
    last_rd = 32'h0;
    @(negedge clk); rst = 1'b0;
    access(0, 1, 0, 32'h0, 0);
    access(1, 0, 6, 32'h0BADF00D, 0);

    for (int k = 0; k < 40; k++) begin
      int op;
      op = int'($urandom_range(0, 2));
      access(op != 1, op != 0, int'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
